// File: rtl/fire_conv_sched.sv
// fire_conv_sched: per-pixel sequencer for the 9-PE fire convolution datapath.
// Each output gets one accumulator clear, a run of input/weight reads with
// ld_MAC trailing the reads by one cycle, then a valid/ready result write.
module fire_conv_sched #(
  parameter int ADDR_W = 10,
  parameter int TAP_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [TAP_W-1:0]         cfg_num_taps,
  input  logic [CNT_W-1:0]         cfg_num_out,
  input  logic [ADDR_W-1:0]        cfg_in_base,
  input  logic [ADDR_W-1:0]        cfg_w_base,
  input  logic [ADDR_W-1:0]        cfg_out_base,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        in_addr,
  output logic [ADDR_W-1:0]        w_addr,
  output logic                     pe_clear,
  output logic                     ld_MAC,
  input  logic signed [7:0]        pe_sum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [7:0]        out_data,
  output logic [ADDR_W-1:0]        out_addr,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACC,
    WRITE,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [TAP_W-1:0]  k;
  logic [TAP_W-1:0]  num_taps;
  logic [CNT_W-1:0]  out_idx;
  logic [CNT_W-1:0]  num_out;
  logic [ADDR_W-1:0] ip;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] out_base;

  logic zero_cfg;
  logic acc_read;
  logic last_out;
  logic handshake;

  // A zero tap count or zero output count skips straight to the done pulse.
  assign zero_cfg  = (cfg_num_taps == '0) || (cfg_num_out == '0);
  // In ACC a read is still issued until tap index k reaches the tap count;
  // the cycle with k == num_taps only loads the last tap.
  assign acc_read  = (k < num_taps);
  assign last_out  = (out_idx == (num_out - CNT_W'(1)));
  assign handshake = (state == WRITE) && out_ready;

  // State register.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection for the per-pixel clear / accumulate / write loop.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = zero_cfg ? DONE : CLEAR;
        end
      end
      CLEAR: next_state = ACC;
      ACC: begin
        if (!acc_read) begin
          next_state = WRITE;
        end
      end
      WRITE: begin
        if (handshake) begin
          next_state = last_out ? DONE : CLEAR;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Latched configuration, input pointer and tap/output counters.
  always_ff @(posedge Clk) begin
    if (reset) begin
      k        <= '0;
      num_taps <= '0;
      out_idx  <= '0;
      num_out  <= '0;
      ip       <= '0;
      w_base   <= '0;
      out_base <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            num_taps <= cfg_num_taps;
            num_out  <= cfg_num_out;
            w_base   <= cfg_w_base;
            out_base <= cfg_out_base;
            ip       <= cfg_in_base;
            k        <= '0;
            out_idx  <= '0;
          end
        end
        CLEAR: begin
          ip <= ip + ADDR_W'(1);
          k  <= TAP_W'(1);
        end
        ACC: begin
          if (acc_read) begin
            ip <= ip + ADDR_W'(1);
            k  <= k + TAP_W'(1);
          end
        end
        WRITE: begin
          if (handshake && !last_out) begin
            out_idx <= out_idx + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode; everything not belonging to the current state is held at 0.
  always_comb begin
    rd_en     = 1'b0;
    in_addr   = '0;
    w_addr    = '0;
    pe_clear  = 1'b0;
    ld_MAC    = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_addr  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      CLEAR: begin
        busy     = 1'b1;
        pe_clear = 1'b1;
        rd_en    = 1'b1;
        in_addr  = ip;
        w_addr   = w_base;
      end
      ACC: begin
        busy   = 1'b1;
        ld_MAC = 1'b1;
        if (acc_read) begin
          rd_en   = 1'b1;
          in_addr = ip;
          w_addr  = w_base + ADDR_W'(k);
        end
      end
      WRITE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = pe_sum;
        out_addr  = out_base + ADDR_W'(out_idx);
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_fire_conv_sched.sv
// tb_fire_conv_sched: directed cycle-by-cycle checks of the convolution
// sequencer; expected vectors come from the nominal per-pixel schedule.
module tb_fire_conv_sched;

  localparam int ADDR_W = 10;
  localparam int TAP_W  = 4;
  localparam int CNT_W  = 8;
  localparam int VW     = 6 + 3 * ADDR_W + 8;

  logic                 Clk;
  logic                 reset;
  logic                 start;
  logic [TAP_W-1:0]     cfg_num_taps;
  logic [CNT_W-1:0]     cfg_num_out;
  logic [ADDR_W-1:0]    cfg_in_base;
  logic [ADDR_W-1:0]    cfg_w_base;
  logic [ADDR_W-1:0]    cfg_out_base;
  logic                 rd_en;
  logic [ADDR_W-1:0]    in_addr;
  logic [ADDR_W-1:0]    w_addr;
  logic                 pe_clear;
  logic                 ld_MAC;
  logic signed [7:0]    pe_sum;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [7:0]    out_data;
  logic [ADDR_W-1:0]    out_addr;
  logic                 busy;
  logic                 done;

  logic [5:0]           ctl;

  int vec_count;
  int err_count;

  logic [5:0]           log_ctl [64];
  logic [ADDR_W-1:0]    log_in  [64];
  logic [ADDR_W-1:0]    log_w   [64];
  logic [ADDR_W-1:0]    log_oa  [64];
  logic [7:0]           log_od  [64];

  fire_conv_sched #(
    .ADDR_W(ADDR_W),
    .TAP_W (TAP_W),
    .CNT_W (CNT_W)
  ) dut (
    .Clk         (Clk),
    .reset       (reset),
    .start       (start),
    .cfg_num_taps(cfg_num_taps),
    .cfg_num_out (cfg_num_out),
    .cfg_in_base (cfg_in_base),
    .cfg_w_base  (cfg_w_base),
    .cfg_out_base(cfg_out_base),
    .rd_en       (rd_en),
    .in_addr     (in_addr),
    .w_addr      (w_addr),
    .pe_clear    (pe_clear),
    .ld_MAC      (ld_MAC),
    .pe_sum      (pe_sum),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .busy        (busy),
    .done        (done)
  );

  assign ctl = {pe_clear, rd_en, ld_MAC, out_valid, done, busy};

  // Free-running clock, period 10.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [VW-1:0] cur_vec();
    return {ctl, in_addr, w_addr, out_addr, out_data};
  endfunction

  function automatic logic [VW-1:0] pack_log(input int j);
    return {log_ctl[j], log_in[j], log_w[j], log_oa[j], log_od[j]};
  endfunction

  // Expected outputs for cycle c after the start edge (c=0 is the first
  // cycle after that edge), assuming out_ready is high in every WRITE.
  // Control bits are {pe_clear, rd_en, ld_MAC, out_valid, done, busy}.
  function automatic logic [VW-1:0] exp_vec(input int c, input int t, input int n,
                                            input int b, input int w, input int o,
                                            input logic [7:0] d);
    logic [5:0]        ctl_e;
    logic [ADDR_W-1:0] in_e;
    logic [ADDR_W-1:0] w_e;
    logic [ADDR_W-1:0] oa_e;
    logic [7:0]        od_e;
    int p;
    int idx;
    int ph;
    ctl_e = '0;
    in_e  = '0;
    w_e   = '0;
    oa_e  = '0;
    od_e  = '0;
    if (t == 0 || n == 0) begin
      if (c == 0) ctl_e = 6'b000011;
    end else begin
      p   = t + 2;
      idx = c / p;
      ph  = c % p;
      if (c < n * p) begin
        if (ph == 0)      ctl_e = 6'b110001;
        else if (ph < t)  ctl_e = 6'b011001;
        else if (ph == t) ctl_e = 6'b001001;
        else              ctl_e = 6'b000101;
        if (ph < t) begin
          in_e = ADDR_W'(b + idx * t + ph);
          w_e  = ADDR_W'(w + ph);
        end
        if (ph == t + 1) begin
          oa_e = ADDR_W'(o + idx);
          od_e = d;
        end
      end else if (c == n * p) begin
        ctl_e = 6'b000011;
      end
    end
    return {ctl_e, in_e, w_e, oa_e, od_e};
  endfunction

  // Drive a start command; must be called just after a rising edge.
  task automatic applyStimulus(input int taps, input int num, input int ib,
                               input int wb, input int ob);
    cfg_num_taps = TAP_W'(taps);
    cfg_num_out  = CNT_W'(num);
    cfg_in_base  = ADDR_W'(ib);
    cfg_w_base   = ADDR_W'(wb);
    cfg_out_base = ADDR_W'(ob);
    start        = 1'b1;
  endtask

  // Record outputs for n cycles, sampled 1 time unit after each rising edge.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
      start      = 1'b0;
      log_ctl[i] = ctl;
      log_in[i]  = in_addr;
      log_w[i]   = w_addr;
      log_oa[i]  = out_addr;
      log_od[i]  = out_data;
    end
  endtask

  // Reset drives every output to zero and leaves the block idle.
  task automatic test_reset();
    logic [VW-1:0] got;
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    pe_sum    = 8'sh11;
    applyStimulus(0, 0, 0, 0, 0);
    start = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    got = cur_vec();
    vec_count++;
    if (got !== '0) begin
      $display("[TB] FAIL reset_hold: got %h expected 0", got);
      err_count++;
    end
    reset = 1'b0;
    @(posedge Clk);
    #1;
    got = cur_vec();
    vec_count++;
    if (got !== '0) begin
      $display("[TB] FAIL reset_idle: got %h expected 0", got);
      err_count++;
    end
  endtask

  // One output, nine taps: 11 cycles to the write, then done.
  task automatic test_single_output();
    logic [VW-1:0] exp;
    pe_sum = 8'sh5A;
    applyStimulus(9, 1, 0, 16, 100);
    capture(13);
    for (int j = 0; j < 13; j++) begin
      exp = exp_vec(j, 9, 1, 0, 16, 100, 8'h5A);
      vec_count++;
      if (pack_log(j) !== exp) begin
        $display("[TB] FAIL single_output cyc %0d: got %h expected %h", j, pack_log(j), exp);
        err_count++;
      end
    end
  endtask

  // Three outputs, four taps: contiguous input addresses, repeating weights.
  task automatic test_three_outputs();
    logic [VW-1:0] exp;
    pe_sum = -8'sd3;
    applyStimulus(4, 3, 0, 16, 100);
    capture(21);
    for (int j = 0; j < 21; j++) begin
      exp = exp_vec(j, 4, 3, 0, 16, 100, 8'hFD);
      vec_count++;
      if (pack_log(j) !== exp) begin
        $display("[TB] FAIL three_outputs cyc %0d: got %h expected %h", j, pack_log(j), exp);
        err_count++;
      end
    end
  endtask

  // out_ready low holds WRITE; the next CLEAR follows the cycle ready rises.
  task automatic test_backpressure();
    logic [VW-1:0] exp;
    logic [VW-1:0] got;
    pe_sum    = 8'sh27;
    out_ready = 1'b0;
    applyStimulus(2, 2, 5, 8, 50);
    capture(3);
    for (int j = 0; j < 3; j++) begin
      exp = exp_vec(j, 2, 2, 5, 8, 50, 8'h27);
      vec_count++;
      if (pack_log(j) !== exp) begin
        $display("[TB] FAIL backpressure_pre cyc %0d: got %h expected %h", j, pack_log(j), exp);
        err_count++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      #1;
      got = cur_vec();
      exp = exp_vec(3, 2, 2, 5, 8, 50, 8'h27);
      vec_count++;
      if (got !== exp) begin
        $display("[TB] FAIL backpressure_hold cyc %0d: got %h expected %h", i, got, exp);
        err_count++;
      end
    end
    out_ready = 1'b1;
    capture(6);
    for (int j = 0; j < 6; j++) begin
      exp = exp_vec(4 + j, 2, 2, 5, 8, 50, 8'h27);
      vec_count++;
      if (pack_log(j) !== exp) begin
        $display("[TB] FAIL backpressure_post cyc %0d: got %h expected %h", j, pack_log(j), exp);
        err_count++;
      end
    end
  endtask

  // Zero taps or zero outputs give a lone busy/done cycle; one tap has no ACC read.
  task automatic test_degenerate();
    logic [VW-1:0] exp;
    pe_sum = 8'sh33;
    applyStimulus(0, 3, 1, 2, 3);
    capture(3);
    for (int j = 0; j < 3; j++) begin
      exp = exp_vec(j, 0, 3, 1, 2, 3, 8'h33);
      vec_count++;
      if (pack_log(j) !== exp) begin
        $display("[TB] FAIL zero_taps cyc %0d: got %h expected %h", j, pack_log(j), exp);
        err_count++;
      end
    end
    applyStimulus(5, 0, 1, 2, 3);
    capture(3);
    for (int j = 0; j < 3; j++) begin
      exp = exp_vec(j, 5, 0, 1, 2, 3, 8'h33);
      vec_count++;
      if (pack_log(j) !== exp) begin
        $display("[TB] FAIL zero_outputs cyc %0d: got %h expected %h", j, pack_log(j), exp);
        err_count++;
      end
    end
    applyStimulus(1, 2, 30, 60, 90);
    capture(8);
    for (int j = 0; j < 8; j++) begin
      exp = exp_vec(j, 1, 2, 30, 60, 90, 8'h33);
      vec_count++;
      if (pack_log(j) !== exp) begin
        $display("[TB] FAIL one_tap cyc %0d: got %h expected %h", j, pack_log(j), exp);
        err_count++;
      end
    end
  endtask

  // A start pulse mid-ACC with a different config must not disturb the pass.
  task automatic test_ignored_start();
    logic [VW-1:0] exp;
    pe_sum    = 8'sh40;
    out_ready = 1'b1;
    applyStimulus(3, 2, 20, 40, 200);
    capture(2);
    for (int j = 0; j < 2; j++) begin
      exp = exp_vec(j, 3, 2, 20, 40, 200, 8'h40);
      vec_count++;
      if (pack_log(j) !== exp) begin
        $display("[TB] FAIL ignored_start_pre cyc %0d: got %h expected %h", j, pack_log(j), exp);
        err_count++;
      end
    end
    applyStimulus(7, 5, 300, 500, 600);
    capture(10);
    for (int j = 0; j < 10; j++) begin
      exp = exp_vec(2 + j, 3, 2, 20, 40, 200, 8'h40);
      vec_count++;
      if (pack_log(j) !== exp) begin
        $display("[TB] FAIL ignored_start cyc %0d: got %h expected %h", j, pack_log(j), exp);
        err_count++;
      end
    end
  endtask

  // Reset during the second output's ACC abandons the pass without done.
  task automatic test_reset_mid_pass();
    logic [VW-1:0] exp;
    logic [VW-1:0] got;
    pe_sum = 8'sh12;
    applyStimulus(3, 3, 10, 0, 0);
    capture(7);
    for (int j = 0; j < 7; j++) begin
      exp = exp_vec(j, 3, 3, 10, 0, 0, 8'h12);
      vec_count++;
      if (pack_log(j) !== exp) begin
        $display("[TB] FAIL mid_reset_pre cyc %0d: got %h expected %h", j, pack_log(j), exp);
        err_count++;
      end
    end
    reset = 1'b1;
    @(posedge Clk);
    #1;
    reset = 1'b0;
    got = cur_vec();
    vec_count++;
    if (got !== '0) begin
      $display("[TB] FAIL mid_reset_outputs: got %h expected 0", got);
      err_count++;
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      #1;
      got = cur_vec();
      vec_count++;
      if (got !== '0) begin
        $display("[TB] FAIL mid_reset_quiet cyc %0d: got %h expected 0", i, got);
        err_count++;
      end
    end
    applyStimulus(3, 3, 10, 0, 0);
    capture(16);
    for (int j = 0; j < 16; j++) begin
      exp = exp_vec(j, 3, 3, 10, 0, 0, 8'h12);
      vec_count++;
      if (pack_log(j) !== exp) begin
        $display("[TB] FAIL mid_reset_restart cyc %0d: got %h expected %h", j, pack_log(j), exp);
        err_count++;
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    vec_count = 0;
    err_count = 0;
    test_reset();
    test_single_output();
    test_three_outputs();
    test_backpressure();
    test_degenerate();
    test_ignored_start();
    test_reset_mid_pass();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
